// File: rtl/pipe_mem_arbiter.sv
// Arbiter that shares one single-port memory between the fetch and data ports of a pipelined CPU.
// Optional feature: define PIPE_MEM_ARB_RR_EN for round-robin arbitration (default is fixed data priority).
module pipe_mem_arbiter #(
  parameter int LAT = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ireq,
  input  logic [31:0] iaddr,
  output logic [31:0] irdata,
  output logic        ivalid,
  output logic        istall,
  input  logic        dreq,
  input  logic        dwe,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  output logic [31:0] drdata,
  output logic        dvalid,
  output logic        dstall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [2:0] LAT_C = 3'(LAT);

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic        gnt_d;
  logic        we_r;
  logic        grant;
  logic        grant_d;
  logic        pick_d;

`ifdef PIPE_MEM_ARB_RR_EN
  logic last_d;

  // Under contention the port that was not granted last wins.
  assign pick_d = dreq & ~(ireq & last_d);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      last_d <= 1'b0;
    else if (grant)
      last_d <= grant_d;
  end
`else
  assign pick_d = dreq;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_d   = gnt_d;
    case (state)
      IDLE: begin
        if (ireq | dreq) begin
          grant     = 1'b1;
          grant_d   = pick_d;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = (gnt_d & we_r) ? DONE : WAIT;
      WAIT: begin
        if (cnt == 3'd1)
          state_nxt = DONE;
      end
      DONE: begin
        // The port being acknowledged still holds its request; only the other may be granted.
        if (gnt_d ? ireq : dreq) begin
          grant     = 1'b1;
          grant_d   = ~gnt_d;
          state_nxt = ISSUE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt       <= 3'd0;
      gnt_d     <= 1'b0;
      we_r      <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      irdata    <= 32'd0;
      drdata    <= 32'd0;
    end else begin
      if (grant) begin
        gnt_d <= grant_d;
        if (grant_d) begin
          we_r      <= dwe;
          mem_addr  <= daddr;
          mem_wdata <= dwdata;
        end else begin
          we_r     <= 1'b0;
          mem_addr <= iaddr;
        end
      end
      if (state == ISSUE && !(gnt_d && we_r))
        cnt <= LAT_C;
      else if (state == WAIT)
        cnt <= cnt - 3'd1;
      if (state == WAIT && cnt == 3'd1) begin
        if (gnt_d)
          drdata <= mem_rdata;
        else
          irdata <= mem_rdata;
      end
    end
  end

  // Strobes decode the state directly so an asynchronous reset drops them at once.
  assign mem_en = (state == ISSUE);
  assign mem_we = (state == ISSUE) & gnt_d & we_r;
  assign ivalid = (state == DONE) & ~gnt_d;
  assign dvalid = (state == DONE) & gnt_d;
  assign istall = ireq & ~ivalid;
  assign dstall = dreq & ~dvalid;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Scoreboard bench for pipe_mem_arbiter: expected memory accesses and completions are queued by the
// stimulus and popped by a monitor; a small memory model returns read data exactly LAT cycles late.
module tb_pipe_mem_arbiter;

  localparam int LAT = 2;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        ireq = 1'b0;
  logic [31:0] iaddr = 32'd0;
  logic [31:0] irdata;
  logic        ivalid;
  logic        istall;
  logic        dreq = 1'b0;
  logic        dwe = 1'b0;
  logic [31:0] daddr = 32'd0;
  logic [31:0] dwdata = 32'd0;
  logic [31:0] drdata;
  logic        dvalid;
  logic        dstall;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int c0;

  typedef struct {bit we; logic [31:0] addr; logic [31:0] wdata; int cyc;} mexp_t;
  typedef struct {bit d; bit chkdata; logic [31:0] data; int cyc;} vexp_t;
  mexp_t mq[$];
  vexp_t vq[$];

  pipe_mem_arbiter #(.LAT(LAT)) dut (
    .clock(clock), .resetn(resetn),
    .ireq(ireq), .iaddr(iaddr), .irdata(irdata), .ivalid(ivalid), .istall(istall),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
    .drdata(drdata), .dvalid(dvalid), .dstall(dstall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h40:  mem_val = 32'h8C220004;
      32'h44:  mem_val = 32'h00A63020;
      32'h48:  mem_val = 32'hAC430008;
      32'h20:  mem_val = 32'h12345678;
      32'h30:  mem_val = 32'hCAFEF00D;
      default: mem_val = 32'h5A5A5A5A;
    endcase
  endfunction

  int          rd_cnt = 0;
  logic [31:0] rd_addr = 32'd0;
  always @(posedge clock) begin
    if (mem_en && !mem_we) begin
      rd_cnt  <= LAT;
      rd_addr <= mem_addr;
    end else if (rd_cnt != 0) begin
      rd_cnt <= rd_cnt - 1;
    end
  end
  assign mem_rdata = (rd_cnt == 1) ? mem_val(rd_addr) : 32'hBAD0BAD0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin : monitor
    mexp_t m;
    vexp_t v;
    if (resetn) begin
      if (mem_we && !mem_en) chk("mem_we_without_en", 32'(mem_we), 32'd0);
      if (mem_en) begin
        if (mq.size() == 0) begin
          chk("unexpected_mem_en", 32'(mem_en), 32'd0);
        end else begin
          m = mq.pop_front();
          chk("mem_en_cycle", 32'(cyc), 32'(m.cyc));
          chk("mem_addr", mem_addr, m.addr);
          chk("mem_we", 32'(mem_we), 32'(m.we));
          if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
        end
      end
      if (ivalid && dvalid) chk("both_valid", 32'd1, 32'd0);
      if (ivalid || dvalid) begin
        if (vq.size() == 0) begin
          chk("unexpected_valid", {30'd0, ivalid, dvalid}, 32'd0);
        end else begin
          v = vq.pop_front();
          chk("valid_port", 32'(dvalid), 32'(v.d));
          chk("valid_cycle", 32'(cyc), 32'(v.cyc));
          if (v.chkdata) chk(v.d ? "drdata" : "irdata", v.d ? drdata : irdata, v.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_m(input bit we, input logic [31:0] a, input logic [31:0] wd, input int c);
    mexp_t m;
    m.we = we; m.addr = a; m.wdata = wd; m.cyc = c;
    mq.push_back(m);
  endtask

  task automatic push_v(input bit d, input bit cd, input logic [31:0] data, input int c);
    vexp_t v;
    v.d = d; v.chkdata = cd; v.data = data; v.cyc = c;
    vq.push_back(v);
  endtask

  // Waits (bounded) for the given port's valid, checks its stall fell, then steps past the edge.
  task automatic wait_valid(input bit d);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clock);
      if (d ? dvalid : ivalid) begin
        seen = 1'b1;
        chk(d ? "dstall_at_valid" : "istall_at_valid", 32'(d ? dstall : istall), 32'd0);
      end
    end
    if (!seen) chk(d ? "dvalid_timeout" : "ivalid_timeout", 32'd0, 32'd1);
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_ivalid", 32'(ivalid), 32'd0);
    chk("rst_dvalid", 32'(dvalid), 32'd0);
    chk("rst_istall", 32'(istall), 32'd0);
    chk("rst_dstall", 32'(dstall), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_irdata", irdata, 32'd0);
    chk("rst_drdata", drdata, 32'd0);
    resetn = 1'b1;
    repeat (5) tick();

    // Single fetch with stall profile
    c0 = cyc;
    ireq = 1'b1; iaddr = 32'h40;
    push_m(1'b0, 32'h40, 32'd0, c0 + 1);
    push_v(1'b0, 1'b1, 32'h8C220004, c0 + 4);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clock);
      chk("istall_profile", 32'(istall), 32'(k < 4));
      if (k < 4) tick();
    end
    tick();
    ireq = 1'b0;
    tick();

    // Store, then a fetch that must not write
    c0 = cyc;
    dreq = 1'b1; dwe = 1'b1; daddr = 32'h10; dwdata = 32'hDEADBEEF;
    push_m(1'b1, 32'h10, 32'hDEADBEEF, c0 + 1);
    push_v(1'b1, 1'b0, 32'd0, c0 + 2);
    wait_valid(1'b1);
    dreq = 1'b0; dwe = 1'b0;
    c0 = cyc;
    ireq = 1'b1; iaddr = 32'h44;
    push_m(1'b0, 32'h44, 32'd0, c0 + 1);
    push_v(1'b0, 1'b1, 32'h00A63020, c0 + 4);
    wait_valid(1'b0);
    ireq = 1'b0;
    tick();

    // Simultaneous fetch and load: data first, fetch back-to-back
    c0 = cyc;
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h20;
    ireq = 1'b1; iaddr = 32'h48;
    push_m(1'b0, 32'h20, 32'd0, c0 + 1);
    push_m(1'b0, 32'h48, 32'd0, c0 + 5);
    push_v(1'b1, 1'b1, 32'h12345678, c0 + 4);
    push_v(1'b0, 1'b1, 32'hAC430008, c0 + 8);
    wait_valid(1'b1);
    dreq = 1'b0;
    wait_valid(1'b0);
    ireq = 1'b0;
    tick();

    // Reset during the WAIT of a load
    c0 = cyc;
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h30;
    push_m(1'b0, 32'h30, 32'd0, c0 + 1);
    tick();
    tick();
    #3;
    resetn = 1'b0;
    dreq = 1'b0;
    #1;
    chk("midrst_mem_en", 32'(mem_en), 32'd0);
    chk("midrst_mem_we", 32'(mem_we), 32'd0);
    chk("midrst_dvalid", 32'(dvalid), 32'd0);
    chk("midrst_ivalid", 32'(ivalid), 32'd0);
    chk("midrst_drdata", drdata, 32'd0);
    chk("midrst_irdata", irdata, 32'd0);
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    c0 = cyc;
    ireq = 1'b1; iaddr = 32'h40;
    push_m(1'b0, 32'h40, 32'd0, c0 + 1);
    push_v(1'b0, 1'b1, 32'h8C220004, c0 + 4);
    wait_valid(1'b0);
    ireq = 1'b0;
    tick();

    // Load alone, then contention in IDLE
    c0 = cyc;
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h20;
    push_m(1'b0, 32'h20, 32'd0, c0 + 1);
    push_v(1'b1, 1'b1, 32'h12345678, c0 + 4);
    wait_valid(1'b1);
    dreq = 1'b0;
    tick();
    c0 = cyc;
    dreq = 1'b1; daddr = 32'h30;
    ireq = 1'b1; iaddr = 32'h48;
`ifdef PIPE_MEM_ARB_RR_EN
    push_m(1'b0, 32'h48, 32'd0, c0 + 1);
    push_m(1'b0, 32'h30, 32'd0, c0 + 5);
    push_v(1'b0, 1'b1, 32'hAC430008, c0 + 4);
    push_v(1'b1, 1'b1, 32'hCAFEF00D, c0 + 8);
    wait_valid(1'b0);
    ireq = 1'b0;
    wait_valid(1'b1);
    dreq = 1'b0;
`else
    push_m(1'b0, 32'h30, 32'd0, c0 + 1);
    push_m(1'b0, 32'h48, 32'd0, c0 + 5);
    push_v(1'b1, 1'b1, 32'hCAFEF00D, c0 + 4);
    push_v(1'b0, 1'b1, 32'hAC430008, c0 + 8);
    wait_valid(1'b1);
    dreq = 1'b0;
    wait_valid(1'b0);
    ireq = 1'b0;
`endif

    repeat (6) tick();
    chk("mem_queue_drained", 32'(mq.size()), 32'd0);
    chk("valid_queue_drained", 32'(vq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
